// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: HD44780 init sequencer and two-client bus arbiter.
// Ports: CLOCK_50/RESET_N, req/word/ack x2, backlight, ready/busy, LCD_*.
//
// After reset the block waits T_PWRUP cycles, then issues the 7-command
// init sequence. Once ready, it grants {RS,DATA} words from two requesters
// round-robin. Every word gets setup, enable and post-enable wait timing.
// LCD_RW is tied low. All other outputs are registered.
module lcd_bus_arbiter #(
  parameter int T_PWRUP = 1000000,
  parameter int T_SETUP = 2,
  parameter int T_EN    = 16,
  parameter int T_WAIT  = 262144,
  parameter int T_LONG  = 100000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       req0,
  input  logic [8:0] word0,
  output logic       ack0,
  input  logic       req1,
  input  logic [8:0] word1,
  output logic       ack1,
  input  logic       backlight,
  output logic       ready,
  output logic       busy,
  output logic       LCD_ON,
  output logic       LCD_BLON,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  localparam int T_LW = (T_LONG > T_WAIT) ? T_LONG : T_WAIT;

  localparam logic [19:0] L_PWRUP = 20'(T_PWRUP - 1);
  localparam logic [19:0] L_SETUP = 20'(T_SETUP - 1);
  localparam logic [19:0] L_EN    = 20'(T_EN - 1);
  localparam logic [19:0] L_WAIT  = 20'(T_WAIT - 1);
  localparam logic [19:0] L_LWAIT = 20'(T_LW - 1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_ISETUP,
    S_IEN,
    S_IWAIT,
    S_IDLE,
    S_SETUP,
    S_EN_HI,
    S_WAIT
  } state_t;

  state_t      state, state_n;
  logic [19:0] cnt, cnt_n, cnt_dec;
  logic [2:0]  idx, idx_n;
  logic        ptr, ptr_n;
  logic        rs_q, rs_n;
  logic [7:0]  data_q, data_n;
  logic        en_q, en_n;
  logic        ack0_q, ack0_n;
  logic        ack1_q, ack1_n;
  logic        ready_q, ready_n;
  logic        busy_q;
  logic        blon_q;
  logic        on_q;
  logic        done;
  logic        gnt1;
  logic [19:0] post_wait;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    logic [7:0] c;
    case (i)
      3'd0:    c = 8'h30;
      3'd1:    c = 8'h30;
      3'd2:    c = 8'h30;
      3'd3:    c = 8'h38;
      3'd4:    c = 8'h0C;
      3'd5:    c = 8'h01;
      default: c = 8'h06;
    endcase
    return c;
  endfunction

  assign done    = (cnt == 20'd0);
  assign cnt_dec = cnt - 20'd1;

  // Tie goes to whoever was not granted last (ptr holds the last grant).
  assign gnt1 = req1 & (~req0 | ~ptr);

  // Clear (0x01) and home (0x02/0x03) need the long settle time.
  assign post_wait = (!rs_q && data_q[7:2] == 6'd0) ? L_LWAIT : L_WAIT;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    ptr_n   = ptr;
    rs_n    = rs_q;
    data_n  = data_q;
    en_n    = en_q;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    ready_n = ready_q;
    unique case (state)
      S_PWRUP: begin
        if (done) begin
          state_n = S_ISETUP;
          cnt_n   = L_SETUP;
          rs_n    = 1'b0;
          data_n  = init_cmd(idx);
        end else begin
          cnt_n = cnt_dec;
        end
      end
      S_ISETUP: begin
        if (done) begin
          state_n = S_IEN;
          cnt_n   = L_EN;
          en_n    = 1'b1;
        end else begin
          cnt_n = cnt_dec;
        end
      end
      S_IEN: begin
        if (done) begin
          state_n = S_IWAIT;
          cnt_n   = post_wait;
          en_n    = 1'b0;
        end else begin
          cnt_n = cnt_dec;
        end
      end
      S_IWAIT: begin
        if (done) begin
          if (idx == 3'd6) begin
            state_n = S_IDLE;
            ready_n = 1'b1;
          end else begin
            idx_n   = 3'(idx + 3'd1);
            state_n = S_ISETUP;
            cnt_n   = L_SETUP;
            data_n  = init_cmd(3'(idx + 3'd1));
          end
        end else begin
          cnt_n = cnt_dec;
        end
      end
      S_IDLE: begin
        if (ready_q && (req0 || req1)) begin
          state_n = S_SETUP;
          cnt_n   = L_SETUP;
          ptr_n   = gnt1;
          ack1_n  = gnt1;
          ack0_n  = ~gnt1;
          rs_n    = gnt1 ? word1[8] : word0[8];
          data_n  = gnt1 ? word1[7:0] : word0[7:0];
        end
      end
      S_SETUP: begin
        if (done) begin
          state_n = S_EN_HI;
          cnt_n   = L_EN;
          en_n    = 1'b1;
        end else begin
          cnt_n = cnt_dec;
        end
      end
      S_EN_HI: begin
        if (done) begin
          state_n = S_WAIT;
          cnt_n   = post_wait;
          en_n    = 1'b0;
        end else begin
          cnt_n = cnt_dec;
        end
      end
      S_WAIT: begin
        if (done) begin
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt_dec;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_PWRUP;
      cnt     <= L_PWRUP;
      idx     <= 3'd0;
      ptr     <= 1'b1;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      blon_q  <= 1'b0;
      on_q    <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      ptr     <= ptr_n;
      rs_q    <= rs_n;
      data_q  <= data_n;
      en_q    <= en_n;
      ack0_q  <= ack0_n;
      ack1_q  <= ack1_n;
      ready_q <= ready_n;
      busy_q  <= (state_n != S_IDLE);
      blon_q  <= backlight;
      on_q    <= 1'b1;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign LCD_ON   = on_q;
  assign LCD_BLON = blon_q;
  assign LCD_EN   = en_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_DATA = data_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: vectors, corner sequences and random traffic
// for lcd_bus_arbiter with short timing parameters.
module tb_lcd_bus_arbiter;

  localparam int TP  = 10;
  localparam int TS  = 2;
  localparam int TE  = 4;
  localparam int TW  = 8;
  localparam int TL  = 20;
  localparam int TLW = (TL > TW) ? TL : TW;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [8:0] word0 = '0;
  logic [8:0] word1 = '0;
  logic       backlight = 1'b0;
  logic       ack0, ack1, ready, busy;
  logic       LCD_ON, LCD_BLON, LCD_EN, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;

  lcd_bus_arbiter #(
    .T_PWRUP(TP), .T_SETUP(TS), .T_EN(TE),
    .T_WAIT(TW), .T_LONG(TL)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
    .req0(req0), .word0(word0), .ack0(ack0),
    .req1(req1), .word1(word1), .ack1(ack1),
    .backlight(backlight), .ready(ready), .busy(busy),
    .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON), .LCD_EN(LCD_EN),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [8:0] w0;
    logic [8:0] w1;
    int         g;
    int         wt;
    logic       late;
    logic [8:0] lw;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] cmds[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  function automatic int wait_for(input logic [8:0] w);
    return (!w[8] && w[7:2] == 6'd0) ? TLW : TW;
  endfunction

  function automatic logic [8:0] rand_word();
    if ($urandom_range(3) == 0)
      return {7'd0, 2'($urandom_range(3))};
    return 9'($urandom);
  endfunction

  task automatic chk_reset_vals(input string t);
    chk({t, "_rst_en"}, LCD_EN, 0);
    chk({t, "_rst_rs"}, LCD_RS, 0);
    chk({t, "_rst_data"}, LCD_DATA, 0);
    chk({t, "_rst_rw"}, LCD_RW, 0);
    chk({t, "_rst_on"}, LCD_ON, 1);
    chk({t, "_rst_blon"}, LCD_BLON, 0);
    chk({t, "_rst_ack"}, {ack0, ack1}, 0);
    chk({t, "_rst_ready"}, ready, 0);
    chk({t, "_rst_busy"}, busy, 1);
  endtask

  // Starts at the sample where RESET_N was just released.
  task automatic check_init(input string t);
    int n;
    int bad;
    bad = 0;
    n = 0;
    while (!LCD_EN && n < 200) begin
      if (ack0 || ack1 || ready) bad++;
      n++;
      tick();
    end
    chk({t, "_lead"}, n, TP + TS);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("%s_cmd%0d_rs", t, i), LCD_RS, 0);
      chk($sformatf("%s_cmd%0d_data", t, i), LCD_DATA, cmds[i]);
      n = 0;
      while (LCD_EN && n < 200) begin
        if (ack0 || ack1 || ready) bad++;
        n++;
        tick();
      end
      chk($sformatf("%s_cmd%0d_en", t, i), n, TE);
      n = 0;
      if (i < 6) begin
        while (!LCD_EN && n < 200) begin
          if (ack0 || ack1 || ready) bad++;
          n++;
          tick();
        end
        chk($sformatf("%s_gap%0d", t, i), n,
            (cmds[i] == 8'h01 ? TLW : TW) + TS);
      end else begin
        while (!ready && n < 200) begin
          if (ack0 || ack1 || LCD_EN) bad++;
          n++;
          tick();
        end
        chk({t, "_ready_delay"}, n, TW);
        chk({t, "_ready_busy"}, busy, 0);
      end
    end
    chk({t, "_quiet"}, bad, 0);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int n;
    int bad;
    logic [8:0] ew;
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    chk($sformatf("v%0d_idle", k), busy, 0);
    req0 = v.r0;
    req1 = v.r1;
    word0 = v.w0;
    word1 = v.w1;
    tick();
    ew = (v.g == 1) ? v.w1 : v.w0;
    chk($sformatf("v%0d_ack", k), {ack1, ack0},
        (v.g == 1) ? 2'b10 : 2'b01);
    chk($sformatf("v%0d_word", k), {LCD_RS, LCD_DATA}, ew);
    chk($sformatf("v%0d_busy", k), busy, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    if (v.late) begin
      req0 = 1'b1;
      word0 = v.lw;
    end
    bad = 0;
    n = 1;
    tick();
    while (!LCD_EN && n < 200) begin
      if (ack0 || ack1) bad++;
      n++;
      tick();
    end
    chk($sformatf("v%0d_setup", k), n, TS);
    n = 0;
    while (LCD_EN && n < 200) begin
      if (ack0 || ack1 || {LCD_RS, LCD_DATA} != ew) bad++;
      n++;
      tick();
    end
    chk($sformatf("v%0d_en", k), n, TE);
    n = 0;
    while (busy && n < 200) begin
      if (ack0 || ack1 || LCD_EN) bad++;
      n++;
      tick();
    end
    chk($sformatf("v%0d_wait", k), n, v.wt);
    chk($sformatf("v%0d_quiet", k), bad, 0);
  endtask

  task automatic random_phase();
    logic [8:0] q[$];
    logic [8:0] held;
    logic [8:0] w;
    logic pr0, pr1, pbl, pen;
    logic [8:0] pw0, pw1;
    int next_free;
    int last;
    int eg;
    bit exp_ack;
    last = 1;
    next_free = 1;
    pr0 = req0;
    pr1 = req1;
    pw0 = word0;
    pw1 = word1;
    pbl = backlight;
    pen = LCD_EN;
    held = '0;
    for (int c = 1; c <= 1700; c++) begin
      tick();
      chk("rnd_blon", LCD_BLON, pbl);
      exp_ack = (c >= next_free) && (pr0 || pr1);
      if (exp_ack) begin
        if (pr0 && pr1) eg = (last == 0) ? 1 : 0;
        else eg = pr1 ? 1 : 0;
        chk($sformatf("rnd_ack_c%0d", c), {ack1, ack0},
            (eg == 1) ? 2'b10 : 2'b01);
        w = (eg == 1) ? pw1 : pw0;
        q.push_back(w);
        last = eg;
        next_free = c + 1 + TS + TE + wait_for(w);
      end else if (ack0 || ack1) begin
        chk($sformatf("rnd_stray_c%0d", c), {ack1, ack0}, 0);
      end
      if (LCD_EN && !pen) begin
        if (q.size() == 0) begin
          chk("rnd_bus_unexpected", {LCD_RS, LCD_DATA}, 'x);
        end else begin
          held = q.pop_front();
          chk($sformatf("rnd_bus_c%0d", c), {LCD_RS, LCD_DATA}, held);
        end
      end else if (LCD_EN && pen && {LCD_RS, LCD_DATA} != held) begin
        chk($sformatf("rnd_stable_c%0d", c), {LCD_RS, LCD_DATA}, held);
      end
      pen = LCD_EN;
      if (c > 1500) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end else begin
        if (ack0) begin
          req0 = ($urandom_range(1) == 1);
          word0 = rand_word();
        end else if (req0) begin
          if ($urandom_range(15) == 0) req0 = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          req0 = 1'b1;
          word0 = rand_word();
        end
        if (ack1) begin
          req1 = ($urandom_range(1) == 1);
          word1 = rand_word();
        end else if (req1) begin
          if ($urandom_range(15) == 0) req1 = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          req1 = 1'b1;
          word1 = rand_word();
        end
      end
      if ($urandom_range(7) == 0) backlight = ~backlight;
      pr0 = req0;
      pr1 = req1;
      pw0 = word0;
      pw1 = word1;
      pbl = backlight;
    end
    chk("rnd_drained", q.size(), 0);
    chk("rnd_end_busy", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    cmds = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
    vecs[0] = '{1, 1, 9'h141, 9'h142, 0, TW, 0, 9'h000};
    vecs[1] = '{1, 1, 9'h141, 9'h142, 1, TW, 0, 9'h000};
    vecs[2] = '{1, 1, 9'h141, 9'h142, 0, TW, 0, 9'h000};
    vecs[3] = '{1, 1, 9'h141, 9'h142, 1, TW, 0, 9'h000};
    vecs[4] = '{1, 0, 9'h14C, 9'h000, 0, TW, 0, 9'h000};
    vecs[5] = '{0, 1, 9'h000, 9'h001, 1, TLW, 1, 9'h102};
    vecs[6] = '{1, 0, 9'h102, 9'h000, 0, TW, 0, 9'h000};
    vecs[7] = '{0, 1, 9'h000, 9'h003, 1, TLW, 0, 9'h000};
    vecs[8] = '{0, 1, 9'h000, 9'h101, 1, TW, 0, 9'h000};
    vecs[9] = '{1, 0, 9'h004, 9'h000, 0, TW, 0, 9'h000};

    tick();
    tick();
    chk_reset_vals("por");
    RESET_N = 1'b1;
    check_init("init1");

    for (int k = 0; k < 10; k++) run_vec(k, vecs[k]);

    // Request pending through reset and init.
    RESET_N = 1'b0;
    tick();
    tick();
    chk_reset_vals("rst2");
    req0 = 1'b1;
    word0 = 9'h155;
    RESET_N = 1'b1;
    check_init("init2");
    tick();
    chk("early_ack0", {ack1, ack0}, 2'b01);
    chk("early_word", {LCD_RS, LCD_DATA}, 9'h155);
    req0 = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    chk("early_done", busy, 0);

    // Reset while the enable strobe of a data write is high.
    req0 = 1'b1;
    word0 = 9'h177;
    tick();
    req0 = 1'b0;
    n = 0;
    while (!LCD_EN && n < 50) begin
      n++;
      tick();
    end
    chk("mid_en_high", LCD_EN, 1);
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_en", LCD_EN, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_busy", busy, 1);
    tick();
    tick();
    RESET_N = 1'b1;
    check_init("init3");

    random_phase();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
